// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the MEM-stage data cache.
//   state_t      - controller FSM states
//   OFFSET_W     - byte offset bits within a 256-bit line
//   WORD_SEL_W   - word-select bits within a line
//   WORD_LSB / INDEX_LSB - bit positions used to slice the byte address
//   TAG_W        - tag width at the default index width
//   tag_width()  - tag width for any index width
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  localparam int OFFSET_W    = 5;
  localparam int WORD_SEL_W  = 3;
  localparam int WORD_LSB    = 2;
  localparam int INDEX_LSB   = OFFSET_W;
  localparam int DEF_INDEX_W = 5;
  localparam int TAG_W       = 32 - OFFSET_W - DEF_INDEX_W;

  function automatic int tag_width(input int index_w);
    return 32 - OFFSET_W - index_w;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: bundles the pipeline-side (p1_*) and memory-side (mem_*)
// signals of the data cache controller.
//   slave  modport - the cache controller (takes p1 requests, drives memory)
//   master modport - the environment (pipeline + off-chip memory)
interface dcache_if #(
  parameter int BLOCK_W = 256
);
  logic               p1_req_i;
  logic               p1_write_i;
  logic [31:0]        p1_addr_i;
  logic [31:0]        p1_data_i;
  logic [31:0]        p1_data_o;
  logic               p1_stall_o;
  logic               mem_enable_o;
  logic               mem_write_o;
  logic [31:0]        mem_addr_o;
  logic [BLOCK_W-1:0] mem_data_o;
  logic [BLOCK_W-1:0] mem_data_i;
  logic               mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: per-line storage of the direct-mapped cache.
//   rd_index            - line selected for both read and write
//   rd_valid/dirty/tag/data - asynchronous read of the selected line
//   wr_en, wr_tag, wr_data, wr_dirty - synchronous line write (sets valid)
// Valid and dirty bits clear asynchronously on rst_i; tag/data need no reset.
module dcache_sram #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22,
  parameter int BLOCK_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic               wr_dirty
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_reg;
  logic [LINES-1:0]   dirty_reg;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[rd_index] <= 1'b1;
      dirty_reg[rd_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_mem[rd_index]  <= wr_tag;
      data_mem[rd_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_dirty = dirty_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// for the MEM stage.
//   clk_i, rst_i - clock and asynchronous active-high reset
//   bus (slave)  - p1_* load/store port to the pipeline, mem_* block port
//                  to off-chip memory (see dcache_if)
// A miss stalls the pipeline while the victim is written back (if dirty)
// and the line is refilled; the held request then completes as a hit.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int BLOCK_W = 256
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);
  localparam int TW = tag_width(INDEX_W);

  state_t state_reg, state_next;

  logic [WORD_SEL_W-1:0] word_sel;
  logic [INDEX_W-1:0]    req_index;
  logic [TW-1:0]         req_tag;
  logic                  line_valid, line_dirty;
  logic [TW-1:0]         line_tag;
  logic [BLOCK_W-1:0]    line_data;
  logic [BLOCK_W-1:0]    merged_block;
  logic                  wr_en, wr_dirty;
  logic [BLOCK_W-1:0]    wr_data;
  logic                  hit;
  logic                  unused_addr_bits;

  assign word_sel         = bus.p1_addr_i[INDEX_LSB-1:WORD_LSB];
  assign req_index        = bus.p1_addr_i[INDEX_LSB+INDEX_W-1:INDEX_LSB];
  assign req_tag          = bus.p1_addr_i[31:INDEX_LSB+INDEX_W];
  assign unused_addr_bits = ^bus.p1_addr_i[WORD_LSB-1:0];

  dcache_sram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TW),
    .BLOCK_W (BLOCK_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_index (req_index),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_tag   (req_tag),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  assign hit = bus.p1_req_i & line_valid & (line_tag == req_tag);

  // Store data replaces one 32-bit word of the resident line.
  always_comb begin
    merged_block = line_data;
    merged_block[{word_sel, 5'b0} +: 32] = bus.p1_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    wr_en            = 1'b0;
    wr_data          = merged_block;
    wr_dirty         = 1'b1;
    case (state_reg)
      IDLE: begin
        if (hit && bus.p1_write_i) begin
          wr_en = 1'b1;
        end else if (bus.p1_req_i && !hit) begin
          state_next = (line_valid && line_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {line_tag, req_index, {OFFSET_W{1'b0}}};
        bus.mem_data_o   = line_data;
        if (bus.mem_ack_i) state_next = REFILL;
      end
      REFILL: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {req_tag, req_index, {OFFSET_W{1'b0}}};
        if (bus.mem_ack_i) begin
          wr_en      = 1'b1;
          wr_data    = bus.mem_data_i;
          wr_dirty   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.p1_stall_o = bus.p1_req_i & ((state_reg != IDLE) | !hit);
  assign bus.p1_data_o  = (hit && state_reg == IDLE) ? line_data[{word_sel, 5'b0} +: 32] : 32'h0;
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scenarios plus randomized loads/stores,
// checked against a line-level cache model and a block memory model.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int LINES = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if #(.BLOCK_W(256)) bus ();

  dcache_controller #(.INDEX_W(5), .BLOCK_W(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: cache lines and backing memory (keyed by block address).
  bit           m_valid [LINES];
  bit           m_dirty [LINES];
  logic [21:0]  m_tag   [LINES];
  logic [255:0] m_data  [LINES];
  logic [255:0] mem_model [logic [31:0]];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] get_block(input logic [31:0] baddr);
    if (!mem_model.exists(baddr)) mem_model[baddr] = rand_block();
    return mem_model[baddr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    bus.p1_req_i = 1'b0;
    #1;
    check("idle_stall", bus.p1_stall_o, 0);
    check("idle_data", bus.p1_data_o, 0);
    check("idle_mem_en", bus.mem_enable_o, 0);
  endtask

  // One load/store: nwb/nrf give the memory ack latency (0 = random).
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int nwb_in, input int nrf_in,
                        output logic [31:0] rdata, output int stalls,
                        output logic [255:0] wb_obs, output bit wb_seen);
    int idx, w, nwb, nrf, exp_stalls;
    logic [21:0] tg;
    logic [31:0] baddr, vaddr;
    logic [255:0] blk;
    bit hit;
    idx    = int'(addr[9:5]);
    w      = int'(addr[4:2]);
    tg     = addr[31:10];
    baddr  = {addr[31:5], 5'b0};
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    nwb    = (nwb_in > 0) ? nwb_in : int'($urandom_range(1, 4));
    nrf    = (nrf_in > 0) ? nrf_in : int'($urandom_range(1, 4));
    stalls = 0;
    wb_seen = 0;
    wb_obs  = '0;
    exp_stalls = 0;

    @(negedge clk);
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = wr;
    bus.p1_addr_i  = addr;
    bus.p1_data_i  = wdata;
    bus.mem_ack_i  = 1'b0;

    if (!hit) begin
      #1;
      check("miss_stall", bus.p1_stall_o, 1);
      check("miss_mem_en", bus.mem_enable_o, 0);
      if (bus.p1_stall_o) stalls++;
      exp_stalls = nrf + 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_stalls += nwb;
        vaddr = {m_tag[idx], addr[9:5], 5'b0};
        for (int k = 1; k <= nwb; k++) begin
          @(negedge clk);
          bus.mem_ack_i  = 1'b0;
          bus.mem_data_i = rand_block();
          #1;
          check("wb_en", bus.mem_enable_o, 1);
          check("wb_write", bus.mem_write_o, 1);
          check("wb_addr", bus.mem_addr_o, vaddr);
          check("wb_data", bus.mem_data_o, m_data[idx]);
          if (bus.p1_stall_o) stalls++;
          wb_obs  = bus.mem_data_o;
          wb_seen = 1;
          if (k == nwb) bus.mem_ack_i = 1'b1;
        end
        mem_model[vaddr] = m_data[idx];
      end
      blk = get_block(baddr);
      for (int k = 1; k <= nrf; k++) begin
        @(negedge clk);
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = rand_block();
        #1;
        check("rf_en", bus.mem_enable_o, 1);
        check("rf_write", bus.mem_write_o, 0);
        check("rf_addr", bus.mem_addr_o, baddr);
        if (bus.p1_stall_o) stalls++;
        if (k == nrf) begin
          bus.mem_data_i = blk;
          bus.mem_ack_i  = 1'b1;
        end
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = blk;
      @(negedge clk);
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = rand_block();
    end

    #1;
    if (bus.p1_stall_o) stalls++;
    check("hit_stall", bus.p1_stall_o, 0);
    check("hit_mem_en", bus.mem_enable_o, 0);
    check("stall_cycles", stalls, exp_stalls);
    rdata = bus.p1_data_o;
    if (!wr) check("load_data", rdata, m_data[idx][w*32 +: 32]);
    @(posedge clk);
    if (wr) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1;
    end
  endtask

  logic [31:0]  rd;
  int           st;
  logic [255:0] wbo;
  bit           wbs;

  initial begin
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = '0;
    bus.p1_data_i  = '0;
    bus.mem_data_i = '0;
    bus.mem_ack_i  = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_en", bus.mem_enable_o, 0);
    check("rst_mem_write", bus.mem_write_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_data", bus.mem_data_o, 0);
    check("rst_stall", bus.p1_stall_o, 0);
    check("rst_data", bus.p1_data_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence.
    mem_model[32'h0000_0400] = {rand_block() >> 32, 32'hDEAD_BEEF};
    access(0, 32'h0000_0400, 0, 0, 3, rd, st, wbo, wbs);
    check("dir_load_word0", rd, 32'hDEAD_BEEF);
    check("dir_miss_stalls", st, 4);
    access(0, 32'h0000_0404, 0, 0, 0, rd, st, wbo, wbs);
    check("dir_hit_stalls", st, 0);
    access(1, 32'h0000_0408, 32'h1234_5678, 0, 0, rd, st, wbo, wbs);
    access(0, 32'h0000_0408, 0, 0, 0, rd, st, wbo, wbs);
    check("dir_store_load", rd, 32'h1234_5678);
    access(0, 32'h0000_1408, 0, 2, 2, rd, st, wbo, wbs);
    check("dir_wb_seen", wbs, 1);
    check("dir_wb_word2", wbo[95:64], 32'h1234_5678);
    check("dir_dirty_stalls", st, 5);
    access(1, 32'h0000_0C10, 32'hCAFE_F00D, 0, 0, rd, st, wbo, wbs);
    check("dir_clean_victim", wbs, 0);
    access(0, 32'h0000_0C10, 0, 0, 0, rd, st, wbo, wbs);
    check("dir_alloc_load", rd, 32'hCAFE_F00D);
    access(0, 32'h0000_0010, 0, 0, 0, rd, st, wbo, wbs);
    check("dir_alloc_dirty", wbs, 1);
    check("dir_alloc_wb_word4", wbo[159:128], 32'hCAFE_F00D);
    idle_check();

    // Randomized loads/stores over a few tags and indices to force conflicts.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2)
          | $urandom_range(0, 3);
      access(($urandom_range(0, 1) == 1), a, $urandom, 0, 0, rd, st, wbo, wbs);
      if ($urandom_range(0, 7) == 0) idle_check();
    end

    // Reset during REFILL: FSM abandons the request and a late ack is ignored.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = 32'h0000_2060;
    #1;
    check("rr_miss_stall", bus.p1_stall_o, 1);
    @(negedge clk);
    #1;
    check("rr_refill_en", bus.mem_enable_o, 1);
    check("rr_refill_addr", bus.mem_addr_o, 32'h0000_2060);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_rst_mem_en", bus.mem_enable_o, 0);
    check("rr_rst_mem_addr", bus.mem_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.p1_req_i = 1'b0;
    @(negedge clk);
    bus.mem_data_i = rand_block();
    bus.mem_ack_i  = 1'b1;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    #1;
    check("rr_late_ack_en", bus.mem_enable_o, 0);
    access(0, 32'h0000_2060, 0, 0, 0, rd, st, wbo, wbs);
    check("rr_still_miss", (st > 0), 1);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
